// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : IF->ID decoupling FIFO holding {inst, pc, order}, flushable.
// Rev 1.0
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [31:0]              enq_inst,
  input  logic [31:0]              enq_pc,
  input  logic [63:0]              enq_order,
  input  logic                     flush,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_inst,
  output logic [31:0]              deq_pc,
  output logic [63:0]              deq_order,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [31:0]   inst_q  [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [63:0]   order_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic w_full, w_empty, w_enq_fire, w_deq_fire;

  assign w_full     = (count_q == C_DEPTH);
  assign w_empty    = (count_q == '0);
  assign enq_ready  = !w_full;
  assign deq_valid  = !w_empty;
  assign w_enq_fire = enq_valid && enq_ready;
  assign w_deq_fire = deq_valid && deq_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      if (w_enq_fire && !w_deq_fire)      count_d = count_q + CW'(1);
      else if (!w_enq_fire && w_deq_fire) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; an enq during flush is dropped by not writing.
  always_ff @(posedge clk) begin
    if (w_enq_fire && !flush) begin
      inst_q[wr_ptr_q]  <= enq_inst;
      pc_q[wr_ptr_q]    <= enq_pc;
      order_q[wr_ptr_q] <= enq_order;
    end
  end

  assign deq_inst  = w_empty ? 32'd0 : inst_q[rd_ptr_q];
  assign deq_pc    = w_empty ? 32'd0 : pc_q[rd_ptr_q];
  assign deq_order = w_empty ? 64'd0 : order_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire
